instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Writer-side counterpart of the opcode decoder: fills instruction memory with words that the decoder later consumes.
- Takes a byte stream from the debug/UART receiver and assembles big-endian 32-bit instruction words.
- Writes each word to consecutive instruction-memory addresses and flags any opcode the decoder does not support.
- Sits between the debug receiver and the instruction-memory write port; active only while the CPU is held in program-load mode.

Parameters:
- ADDR_W, 10, instruction-memory word-address width; capacity is 2^ADDR_W words.
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker; this word is never written to memory.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load session.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  loader accepts the byte this cycle.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  instruction-memory word address.
- imem_wdata  out  32  instruction word to write.
- busy  out  1  session in progress.
- done  out  1  session finished; held high.
- word_count  out  ADDR_W+1  number of words written in the session.
- bad_op  out  1  sticky: at least one written word had an unsupported opcode.
- overflow  out  1  sticky: memory filled before HALT_WORD arrived.

Behaviour:
Reset:
- reset_n=0 at a clock edge forces state=IDLE and clears every output, the byte index, the shift register and the address counter.
- Reset takes effect mid-word or mid-session; the partial word is discarded.

Supported opcodes ([31:26]): 000000, 001000, 010001, 001100, 000100, 000101, 100000, 100100, 100001, 100101, 001111, 100011, 100111, 001101, 101000, 101001, 001010, 001011, 101011, 001110. Any other value is unsupported.

FSM states: IDLE, COLLECT, WRITE, DONE.

IDLE:
- rx_ready=0.
- start=1 -> COLLECT; clear addr, word_count, byte index, bad_op, overflow.

COLLECT:
- rx_ready=1.
- Each cycle with rx_valid=1 shifts rx_data into the word register; the first byte lands in [31:24], the fourth in [7:0].
- The byte index wraps 3->0 after the 4th byte.
- Assembled word == HALT_WORD -> DONE; nothing is written.
- Otherwise -> WRITE.
- Bytes with rx_valid=0 are ignored; gaps of any length are allowed.

WRITE (exactly one cycle):
- rx_ready=0; imem_we=1; imem_addr=current addr; imem_wdata=assembled word.
- bad_op is set if the opcode is unsupported; the word is still written.
- addr and word_count increment.
- If word_count becomes 2^ADDR_W: set overflow and go to DONE.
- Else -> COLLECT.
- The address never wraps.

DONE:
- done=1, rx_ready=0, busy=0.
- word_count, bad_op and overflow hold.
- start=1 -> COLLECT with a fresh session; done clears in the same transition.

Output rules:
- busy=1 exactly in COLLECT and WRITE.
- start is ignored in COLLECT and WRITE.
- imem_we=0 in all states except WRITE; imem_addr and imem_wdata hold their last values outside WRITE.

Throughput: minimum 5 cycles per written word (4 byte cycles + 1 write cycle). A byte presented during WRITE is not accepted, because rx_ready=0.

Latency: imem_we asserts on the cycle after the cycle in which the 4th byte is accepted. done asserts on the cycle after HALT_WORD completes, or after the overflowing write.

Test Plan:
- Load session: bytes 20 08 00 05, 00 00 00 20, FF FF FF FF.
  -> writes 0x20080005@0 and 0x00000020@1.
  -> done=1, word_count=2, bad_op=0, overflow=0, imem_we pulses exactly twice.
- Opcode check: word 0xFC000000 (opcode 111111) then HALT.
  -> written at addr 0, bad_op=1.
  -> a following 0x8C010004 (LW) leaves bad_op=1 (sticky).
- Stalled stream: 0x3C01ABCD (LUI) with 3 idle cycles between each byte.
  -> single correct write; rx_ready stays 1 through the gaps and drops only in WRITE.
- Overflow (ADDR_W=2): five non-HALT words.
  -> writes at addr 0..3, overflow=1, done=1, word_count=4.
  -> the 5th word is never accepted (rx_ready=0).
- Reset mid-word, then restart:
  -> reset_n=0 after 2 bytes of the 2nd word: all outputs return to 0.
  -> new start + 1 word + HALT gives word_count=1 at addr 0.
- Start pulses: start pulsed during COLLECT has no effect. start in DONE begins a new session at addr 0 with bad_op cleared.

Source files
------------

// File: rtl/instr_loader.sv
// Program-load path: assembles big-endian 32-bit words from a byte stream and
// writes them to consecutive instruction-memory addresses until HALT_WORD.
module instr_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              bad_op,
  output logic              overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(1) << ADDR_W;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t            state, state_d;
  logic [1:0]        idx, idx_d;
  logic [31:0]       shreg, shreg_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [31:0]       word_c;

  logic              rx_ready_d, imem_we_d, busy_d, done_d, bad_op_d, overflow_d;
  logic [ADDR_W-1:0] imem_addr_d;
  logic [31:0]       imem_wdata_d;
  logic [CNT_W-1:0]  word_count_d;

  // Opcodes the decoder implements; anything else is flagged but still written.
  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      6'b000000, 6'b001000, 6'b010001, 6'b001100, 6'b000100,
      6'b000101, 6'b100000, 6'b100100, 6'b100001, 6'b100101,
      6'b001111, 6'b100011, 6'b100111, 6'b001101, 6'b101000,
      6'b101001, 6'b001010, 6'b001011, 6'b101011, 6'b001110: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign word_c = {shreg[23:0], rx_data};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= 2'd0;
      shreg      <= 32'd0;
      addr       <= '0;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
      bad_op     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      shreg      <= shreg_d;
      addr       <= addr_d;
      rx_ready   <= rx_ready_d;
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      busy       <= busy_d;
      done       <= done_d;
      word_count <= word_count_d;
      bad_op     <= bad_op_d;
      overflow   <= overflow_d;
    end
  end

  always_comb begin
    state_d      = state;
    idx_d        = idx;
    shreg_d      = shreg;
    addr_d       = addr;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    word_count_d = word_count;
    bad_op_d     = bad_op;
    overflow_d   = overflow;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d      = COLLECT;
          idx_d        = 2'd0;
          addr_d       = '0;
          word_count_d = '0;
          bad_op_d     = 1'b0;
          overflow_d   = 1'b0;
        end
      end
      COLLECT: begin
        if (rx_valid) begin
          shreg_d = word_c;
          idx_d   = idx + 2'd1;
          if (idx == 2'd3) begin
            if (word_c == HALT_WORD) begin
              state_d = DONE;
            end else begin
              state_d      = WRITE;
              imem_we_d    = 1'b1;
              imem_addr_d  = addr;
              imem_wdata_d = word_c;
            end
          end
        end
      end
      WRITE: begin
        if (!op_supported(imem_wdata[31:26])) bad_op_d = 1'b1;
        word_count_d = word_count + CNT_W'(1);
        // Address saturates at the last word; the session ends instead of wrapping.
        if (word_count_d == FULL_COUNT) begin
          overflow_d = 1'b1;
          state_d    = DONE;
        end else begin
          addr_d  = addr + ADDR_W'(1);
          state_d = COLLECT;
        end
      end
      default: state_d = IDLE;
    endcase

    rx_ready_d = (state_d == COLLECT);
    busy_d     = (state_d == COLLECT) || (state_d == WRITE);
    done_d     = (state_d == DONE);
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a default instance plus an ADDR_W=2 instance
// sharing the same stimulus, the small one used for the overflow case.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        reset_n, start, rx_valid;
  logic [7:0]  rx_data;

  logic        rx_ready, imem_we, busy, done, bad_op, overflow;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [10:0] word_count;

  logic        rx_ready2, imem_we2, busy2, done2, bad_op2, overflow2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wdata2;
  logic [2:0]  word_count2;

  int checks = 0;
  int failures = 0;
  logic [63:0] wq[$];
  logic [63:0] wq2[$];

  instr_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done),
    .word_count(word_count), .bad_op(bad_op), .overflow(overflow)
  );

  instr_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready2), .imem_we(imem_we2),
    .imem_addr(imem_addr2), .imem_wdata(imem_wdata2), .busy(busy2), .done(done2),
    .word_count(word_count2), .bad_op(bad_op2), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  // Write log: {address, data} for every cycle with the strobe high.
  always @(posedge clk) begin
    if (imem_we)  wq.push_back({32'(imem_addr), imem_wdata});
    if (imem_we2) wq2.push_back({32'(imem_addr2), imem_wdata2});
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1; rx_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  // Presents a byte and returns just after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("send_timeout", 64'(rx_ready), 64'd1);
    @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] stall_w;
    reset_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_flags", {59'd0, rx_ready, imem_we, busy, done, bad_op}, 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_wc", 64'(word_count), 64'd0);
    check("rst_addr_data", {22'd0, imem_addr, imem_wdata}, 64'd0);

    // Basic load session
    wq.delete(); wq2.delete();
    pulse_start();
    check("start_busy_ready", {62'd0, busy, rx_ready}, 64'd3);
    send_word(32'h2008_0005);
    send_word(32'h0000_0020);
    send_word(32'hFFFF_FFFF);
    idle(2);
    check("load_done", {62'd0, done, busy}, 64'd2);
    check("load_wc", 64'(word_count), 64'd2);
    check("load_flags", {62'd0, bad_op, overflow}, 64'd0);
    check("load_nwr", 64'(wq.size()), 64'd2);
    check("load_w0", wq[0], {32'd0, 32'h2008_0005});
    check("load_w1", wq[1], {32'd1, 32'h0000_0020});

    // Unsupported opcode, then a legal LW; flag stays set
    do_reset();
    wq.delete(); wq2.delete();
    pulse_start();
    send_word(32'hFC00_0000);
    idle(2);
    check("badop_set", 64'(bad_op), 64'd1);
    send_word(32'h8C01_0004);
    send_word(32'hFFFF_FFFF);
    idle(2);
    check("badop_sticky", 64'(bad_op), 64'd1);
    check("badop_wc", 64'(word_count), 64'd2);
    check("badop_w0", wq[0], {32'd0, 32'hFC00_0000});
    check("badop_w1", wq[1], {32'd1, 32'h8C01_0004});

    // Stalled stream: 3 idle cycles between bytes
    do_reset();
    wq.delete(); wq2.delete();
    pulse_start();
    stall_w = 32'h3C01_ABCD;
    for (int i = 0; i < 4; i++) begin
      send_byte(stall_w[31-8*i -: 8]);
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          idle(1);
          check("stall_gap_ready", 64'(rx_ready), 64'd1);
        end
      end
    end
    idle(1);
    check("stall_write_cycle", {61'd0, imem_we, rx_ready, busy}, 64'd5);
    check("stall_wdata", {22'd0, imem_addr, imem_wdata}, {32'd0, 32'h3C01_ABCD});
    idle(1);
    check("stall_after_write", {62'd0, imem_we, rx_ready}, 64'd1);
    check("stall_nwr", 64'(wq.size()), 64'd1);
    check("stall_badop", 64'(bad_op), 64'd0);

    // Overflow on the ADDR_W=2 instance: 5 words, only 4 fit
    do_reset();
    wq.delete(); wq2.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send_word(32'h2000_0000 | 32'(i));
    idle(2);
    check("ovf_ready_closed", {61'd0, rx_ready2, done2, overflow2}, 64'd3);
    send_word(32'h2000_0004);
    idle(2);
    check("ovf_wc", 64'(word_count2), 64'd4);
    check("ovf_busy", 64'(busy2), 64'd0);
    check("ovf_nwr", 64'(wq2.size()), 64'd4);
    check("ovf_w0", wq2[0], {32'd0, 32'h2000_0000});
    check("ovf_w3", wq2[3], {32'd3, 32'h2000_0003});
    check("ovf_addr_hold", 64'(imem_addr2), 64'd3);
    check("big_no_ovf", {53'd0, overflow, word_count}, 64'd5);

    // Reset mid-word, then a clean restart
    do_reset();
    wq.delete(); wq2.delete();
    pulse_start();
    send_word(32'h2008_0005);
    send_byte(8'h00);
    send_byte(8'h00);
    do_reset();
    @(negedge clk);
    check("midrst_flags", {57'd0, rx_ready, imem_we, busy, done, bad_op, overflow}, 64'd0);
    check("midrst_regs", {11'd0, word_count, imem_addr, imem_wdata}, 64'd0);
    wq.delete(); wq2.delete();
    pulse_start();
    send_word(32'h8C22_0008);
    send_word(32'hFFFF_FFFF);
    idle(2);
    check("midrst_wc", 64'(word_count), 64'd1);
    check("midrst_w0", wq[0], {32'd0, 32'h8C22_0008});
    check("midrst_nwr", 64'(wq.size()), 64'd1);

    // start ignored mid-session; start in DONE opens a fresh session
    do_reset();
    wq.delete(); wq2.delete();
    pulse_start();
    send_byte(8'h20);
    pulse_start();
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h05);
    send_word(32'hFC00_0000);
    send_word(32'hFFFF_FFFF);
    idle(2);
    check("sp_done", {61'd0, done, bad_op, busy}, 64'd6);
    check("sp_wc", 64'(word_count), 64'd2);
    check("sp_w0", wq[0], {32'd0, 32'h2008_0005});
    pulse_start();
    check("sp_restart", {60'd0, done, busy, bad_op, rx_ready}, 64'd5);
    check("sp_restart_wc", 64'(word_count), 64'd0);
    send_word(32'h3C01_0001);
    send_word(32'hFFFF_FFFF);
    idle(2);
    check("sp_new_w", wq[2], {32'd0, 32'h3C01_0001});
    check("sp_new_wc", {62'd0, word_count[1:0]}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
